// File: rtl/vec_chunk_feeder.sv
// rtl/vec_chunk_feeder.sv - ping-pong sample-to-chunk packer feeding the vector MAC stages
module vec_chunk_feeder #(
    parameter int InVecLength = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 8
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    in_sample_valid,
    input  logic signed [NBits-1:0]                 in_sample,
    output logic                                    in_sample_ready,
    input  logic                                    req_chunk,
    output logic                                    out_data_ready,
    output logic signed [WorkingRegs-1:0][NBits-1:0] out_chunk,
    output logic                                    out_vector_last
);

    localparam int ChunksPerVec = InVecLength / WorkingRegs;
    localparam int WidxW        = (InVecLength > 1) ? $clog2(InVecLength) : 1;
    localparam int RidxW        = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1;
    localparam logic [WidxW-1:0] WidxLast = WidxW'(InVecLength - 1);
    localparam logic [RidxW-1:0] RidxLast = RidxW'(ChunksPerVec - 1);

    // Element-addressed banks; chunk c lane l lives at element c*WorkingRegs+l.
    logic [NBits-1:0] bank_mem [2][InVecLength];

    logic [1:0]       full;
    logic             wbank;
    logic             rbank;
    logic [WidxW-1:0] widx;
    logic [RidxW-1:0] ridx;
    logic             accept;
    logic             pop;

    assign in_sample_ready = rst_in & ~full[wbank];
    assign out_data_ready  = rst_in & full[rbank];
    assign out_vector_last = out_data_ready & (ridx == RidxLast);
    assign accept          = in_sample_valid & in_sample_ready;
    assign pop             = req_chunk & out_data_ready;

    always_ff @(posedge clk_in) begin
        if (accept) begin
            bank_mem[wbank][widx] <= in_sample;
        end
    end

    // Write and read sides only ever touch different banks, so both flag updates may land together.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            full  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            widx  <= '0;
            ridx  <= '0;
        end else begin
            if (accept) begin
                if (widx == WidxLast) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                    widx        <= '0;
                end else begin
                    widx <= widx + 1'b1;
                end
            end
            if (pop) begin
                if (ridx == RidxLast) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                    ridx        <= '0;
                end else begin
                    ridx <= ridx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        out_chunk = '0;
        if (out_data_ready) begin
            for (int l = 0; l < WorkingRegs; l++) begin
                idx          = int'(ridx) * WorkingRegs + l;
                out_chunk[l] = bank_mem[rbank][idx[WidxW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_vec_chunk_feeder.sv
// tb/tb_vec_chunk_feeder.sv - self-checking bench for vec_chunk_feeder with a queue-based reference model
module tb_vec_chunk_feeder;

    localparam int L = 16;
    localparam int W = 4;
    localparam int C = L / W;

    logic                      clk_in = 1'b0;
    logic                      rst_in = 1'b0;
    logic                      in_sample_valid = 1'b0;
    logic signed [7:0]         in_sample = '0;
    logic                      in_sample_ready;
    logic                      req_chunk = 1'b0;
    logic                      out_data_ready;
    logic signed [W-1:0][7:0]  out_chunk;
    logic                      out_vector_last;

    int errors = 0;
    int checks = 0;

    bit dut_acc;
    bit dut_pop;

    // Reference model: flat queue of complete vectors, current partial vector, head chunk position.
    int vq[$];
    int part[$];
    int pos = 0;

    vec_chunk_feeder #(.InVecLength(L), .WorkingRegs(W), .NBits(8)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .in_sample_valid (in_sample_valid),
        .in_sample       (in_sample),
        .in_sample_ready (in_sample_ready),
        .req_chunk       (req_chunk),
        .out_data_ready  (out_data_ready),
        .out_chunk       (out_chunk),
        .out_vector_last (out_vector_last)
    );

    always #5 clk_in = ~clk_in;

    function automatic int nfull();
        return vq.size() / L;
    endfunction

    function automatic bit m_in_ready();
        return rst_in && (nfull() < 2);
    endfunction

    function automatic bit m_out_ready();
        return rst_in && (nfull() > 0);
    endfunction

    function automatic bit m_last();
        return m_out_ready() && (pos == C - 1);
    endfunction

    function automatic int exp_lane(int l);
        if (!m_out_ready()) return 0;
        return vq[pos * W + l];
    endfunction

    task automatic tick();
        bit acc;
        bit pp;
        int s;
        acc     = in_sample_valid && m_in_ready();
        pp      = req_chunk && m_out_ready();
        s       = int'(in_sample);
        dut_acc = in_sample_valid && in_sample_ready;
        dut_pop = req_chunk && out_data_ready;
        @(posedge clk_in);
        if (!rst_in) begin
            vq.delete();
            part.delete();
            pos = 0;
        end else begin
            if (acc) begin
                part.push_back(s);
                if (part.size() == L) begin
                    foreach (part[i]) vq.push_back(part[i]);
                    part.delete();
                end
            end
            if (pp) begin
                if (pos == C - 1) begin
                    repeat (L) void'(vq.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        in_sample_valid = 1'b0;
        req_chunk       = 1'b0;
        rst_in          = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        int nv[L];
        for (int i = 0; i < 5; i++) begin
            in_sample_valid = 1'b1;
            in_sample       = 8'($urandom);
            tick();
        end
        in_sample_valid = 1'b0;
        rst_in = 1'b0;
        for (int r = 0; r < 2; r++) begin
            tick();
            checks++;
            if ({in_sample_ready, out_data_ready, out_vector_last} !== 3'b000 || out_chunk !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got rdy=%b odr=%b last=%b chunk=%h want all zero",
                         in_sample_ready, out_data_ready, out_vector_last, out_chunk);
            end
        end
        rst_in = 1'b1;
        #1;
        checks++;
        if (in_sample_ready !== 1'b1 || out_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b odr=%b want rdy=1 odr=0", in_sample_ready, out_data_ready);
        end
        for (int i = 0; i < L; i++) begin
            in_sample_valid = 1'b1;
            in_sample       = 8'($urandom);
            nv[i]           = int'(in_sample);
            tick();
        end
        in_sample_valid = 1'b0;
        for (int c = 0; c < C; c++) begin
            for (int l = 0; l < W; l++) begin
                checks++;
                if (out_data_ready !== 1'b1 || $signed(out_chunk[l]) !== nv[c * W + l]) begin
                    errors++;
                    $display("FAIL reset_new_vector c%0d l%0d: got odr=%b val=%0d want odr=1 val=%0d",
                             c, l, out_data_ready, $signed(out_chunk[l]), nv[c * W + l]);
                end
            end
            req_chunk = 1'b1;
            tick();
        end
        req_chunk = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < L; i++) begin
            in_sample_valid = 1'b1;
            in_sample       = 8'(i + 1);
            if (i == L - 1) begin
                checks++;
                if (out_data_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_ready: got %b want 0", out_data_ready);
                end
            end
            tick();
        end
        in_sample_valid = 1'b0;
        for (int c = 0; c < C; c++) begin
            checks++;
            if (out_data_ready !== 1'b1 || out_vector_last !== (c == C - 1)) begin
                errors++;
                $display("FAIL basic_flags c%0d: got odr=%b last=%b want odr=1 last=%b",
                         c, out_data_ready, out_vector_last, (c == C - 1));
            end
            for (int l = 0; l < W; l++) begin
                checks++;
                if ($signed(out_chunk[l]) !== c * W + l + 1) begin
                    errors++;
                    $display("FAIL basic_lane c%0d l%0d: got %0d want %0d", c, l, $signed(out_chunk[l]), c * W + l + 1);
                end
            end
            req_chunk = 1'b1;
            tick();
        end
        req_chunk = 1'b0;
        checks++;
        if (out_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_drained: got odr=%b want 0", out_data_ready);
        end
    endtask

    task automatic test_backpressure();
        int k;
        do_reset();
        k = 0;
        in_sample_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            in_sample = 8'(k + 1);
            tick();
            if (dut_acc) begin
                k++;
                if (k == 2 * L) begin
                    checks++;
                    if (in_sample_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_ready_drop: got %b want 0", in_sample_ready);
                    end
                end
            end
        end
        checks++;
        if (k !== 2 * L || in_sample_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepted: got %0d rdy=%b want %0d rdy=0", k, in_sample_ready, 2 * L);
        end
        for (int c = 0; c < C; c++) begin
            req_chunk = 1'b1;
            tick();
            checks++;
            if (dut_acc !== 1'b0 || dut_pop !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold pop%0d: got acc=%b pop=%b want acc=0 pop=1", c, dut_acc, dut_pop);
            end
        end
        req_chunk = 1'b0;
        tick();
        checks++;
        if (dut_acc !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume: got acc=%b want 1", dut_acc);
        end
        in_sample_valid = 1'b0;
        for (int l = 0; l < W; l++) begin
            checks++;
            if ($signed(out_chunk[l]) !== L + l + 1) begin
                errors++;
                $display("FAIL bp_second_vector l%0d: got %0d want %0d", l, $signed(out_chunk[l]), L + l + 1);
            end
        end
    endtask

    task automatic test_simultaneous();
        int b[L];
        do_reset();
        in_sample_valid = 1'b1;
        for (int i = 0; i < L; i++) begin
            in_sample = 8'($urandom);
            tick();
        end
        for (int i = 0; i < L - 1; i++) begin
            in_sample = 8'($urandom);
            b[i]      = int'(in_sample);
            req_chunk = (i < C - 1);
            tick();
        end
        in_sample = 8'($urandom);
        b[L - 1]  = int'(in_sample);
        req_chunk = 1'b1;
        checks++;
        if (out_vector_last !== 1'b1 || in_sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL sim_setup: got last=%b rdy=%b want 1 1", out_vector_last, in_sample_ready);
        end
        tick();
        in_sample_valid = 1'b0;
        req_chunk       = 1'b0;
        checks++;
        if (dut_acc !== 1'b1 || dut_pop !== 1'b1 || out_data_ready !== 1'b1 || out_vector_last !== 1'b0) begin
            errors++;
            $display("FAIL sim_edge: got acc=%b pop=%b odr=%b last=%b want 1 1 1 0",
                     dut_acc, dut_pop, out_data_ready, out_vector_last);
        end
        for (int l = 0; l < W; l++) begin
            checks++;
            if ($signed(out_chunk[l]) !== b[l]) begin
                errors++;
                $display("FAIL sim_bank_b l%0d: got %0d want %0d", l, $signed(out_chunk[l]), b[l]);
            end
        end
    endtask

    task automatic test_spurious();
        int f[W];
        do_reset();
        req_chunk = 1'b1;
        repeat (3) tick();
        req_chunk = 1'b0;
        for (int i = 0; i < L; i++) begin
            in_sample_valid = 1'b1;
            in_sample       = 8'($urandom);
            if (i < W) f[i] = int'(in_sample);
            req_chunk = 1'($urandom);
            tick();
        end
        in_sample_valid = 1'b0;
        req_chunk       = 1'b0;
        checks++;
        if (out_data_ready !== 1'b1 || out_vector_last !== 1'b0) begin
            errors++;
            $display("FAIL spurious_flags: got odr=%b last=%b want 1 0", out_data_ready, out_vector_last);
        end
        for (int l = 0; l < W; l++) begin
            checks++;
            if ($signed(out_chunk[l]) !== f[l]) begin
                errors++;
                $display("FAIL spurious_chunk0 l%0d: got %0d want %0d", l, $signed(out_chunk[l]), f[l]);
            end
        end
    endtask

    task automatic test_signed();
        int pat[W];
        pat[0] = -128;
        pat[1] = 127;
        pat[2] = -1;
        pat[3] = 0;
        do_reset();
        for (int i = 0; i < L; i++) begin
            in_sample_valid = 1'b1;
            in_sample       = 8'(pat[i % W]);
            tick();
        end
        in_sample_valid = 1'b0;
        for (int c = 0; c < C; c++) begin
            for (int l = 0; l < W; l++) begin
                checks++;
                if ($signed(out_chunk[l]) !== pat[l]) begin
                    errors++;
                    $display("FAIL signed c%0d l%0d: got %0d want %0d", c, l, $signed(out_chunk[l]), pat[l]);
                end
            end
            req_chunk = 1'b1;
            tick();
        end
        req_chunk = 1'b0;
    endtask

    task automatic test_random();
        int vbias;
        int rbias;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) begin
                vbias = $urandom_range(1, 4);
                rbias = $urandom_range(1, 4);
            end
            in_sample_valid = ($urandom_range(0, 4) < vbias);
            in_sample       = 8'($urandom);
            req_chunk       = ($urandom_range(0, 4) < rbias);
            checks++;
            if (in_sample_ready !== m_in_ready() || out_data_ready !== m_out_ready() ||
                out_vector_last !== m_last()) begin
                errors++;
                $display("FAIL random_flags n%0d: got rdy=%b odr=%b last=%b want %b %b %b",
                         n, in_sample_ready, out_data_ready, out_vector_last, m_in_ready(), m_out_ready(), m_last());
            end
            for (int l = 0; l < W; l++) begin
                checks++;
                if ($signed(out_chunk[l]) !== exp_lane(l)) begin
                    errors++;
                    $display("FAIL random_lane n%0d l%0d: got %0d want %0d", n, l, $signed(out_chunk[l]), exp_lane(l));
                end
            end
            tick();
        end
        in_sample_valid = 1'b0;
        req_chunk       = 1'b0;
    endtask

    initial begin
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_simultaneous();
        test_spurious();
        test_signed();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
